// File: rtl/q2_pkg.sv
// Shared definitions for the Q2 accumulator processor: opcodes, OPR micro-op
// bit positions, control states and ALU operation codes.
package q2_pkg;

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_STA = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JSR = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  localparam int unsigned OPR_HLT = 0;
  localparam int unsigned OPR_CLA = 1;
  localparam int unsigned OPR_CLL = 2;
  localparam int unsigned OPR_CMA = 3;
  localparam int unsigned OPR_INC = 4;
  localparam int unsigned OPR_SZA = 5;
  localparam int unsigned OPR_SNA = 6;
  localparam int unsigned OPR_SZL = 7;

  // Console/keyboard live here, outside the CPU; to the core it is plain memory.
  localparam logic [11:0] IO_ADDR = 12'hFFF;

  typedef enum logic [2:0] {
    S_FETCH, S_DEFER, S_READ, S_WSETUP, S_WSTROBE, S_PANEL_WS, S_PANEL_WP
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASSA, ALU_PASSB, ALU_ADD, ALU_AND, ALU_XOR, ALU_COM, ALU_INC
  } alu_op_e;

  function automatic alu_op_e mem_alu_op(input logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_AND:  return ALU_AND;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASSB;
    endcase
  endfunction

endpackage

// File: rtl/q2_alu.sv
// 12-bit combinational ALU for the Q2 core; c_o is the carry out of ADD/INC.
module q2_alu
  import q2_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] y_o,
  output logic        c_o
);

  alu_op_e op;
  assign op = alu_op_e'(op_i);

  always_comb begin
    y_o = a_i;
    c_o = 1'b0;
    case (op)
      ALU_PASSB: y_o = b_i;
      ALU_ADD:   {c_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
      ALU_AND:   y_o = a_i & b_i;
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_COM:   y_o = ~a_i;
      ALU_INC:   {c_o, y_o} = {1'b0, a_i} + 13'd1;
      default:   y_o = a_i;
    endcase
  end

endmodule

// File: rtl/q2_cpu.sv
// Q2 12-bit accumulator CPU: control FSM, register file, front panel and the
// tri-state memory bus interface.
module q2_cpu
  import q2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw,
  inout  wire  [11:0] dbus,
  output logic [11:0] abus,
  output logic        rdm,
  output logic        wrm,
  input  logic        incp_sw,
  input  logic        dep_sw,
  input  logic        start_sw,
  input  logic        stop_sw,
  output logic        run
);

  state_e      state_q, state_d;
  logic [11:0] p_q, p_d, a_q, a_d, ea_q, ea_d;
  logic [2:0]  ir_op_q, ir_op_d;
  logic        l_q, l_d;
  logic        run_q, incp_q, dep_q;

  logic [11:0] p_inc, direct_ea, a1, alu_a, alu_y, wdata;
  logic        l1, l_opr, alu_c, skip, hlt, drive;
  alu_op_e     alu_op;

  wire [2:0] f_op = dbus[11:9];
  wire       incp_rise = incp_sw & ~incp_q;
  wire       dep_rise  = dep_sw & ~dep_q;

  assign p_inc     = p_q + 12'd1;
  assign direct_ea = dbus[7] ? {5'b0, dbus[6:0]} : {p_inc[11:7], dbus[6:0]};

  // OPR stages ahead of the ALU: CLA, CLL, then CMA; INC runs in the ALU.
  assign a1    = dbus[OPR_CLA] ? 12'd0 : a_q;
  assign l1    = dbus[OPR_CLL] ? 1'b0 : l_q;
  assign alu_a = (state_q == S_READ) ? a_q : (dbus[OPR_CMA] ? ~a1 : a1);
  assign alu_op = (state_q == S_READ) ? mem_alu_op(ir_op_q)
                                      : (dbus[OPR_INC] ? ALU_INC : ALU_PASSA);
  assign l_opr = dbus[OPR_INC] ? alu_c : l1;
  assign skip  = (dbus[OPR_SZA] && alu_y == 12'd0) || (dbus[OPR_SNA] && alu_y[11]) ||
                 (dbus[OPR_SZL] && !l_opr);

  q2_alu u_alu (
    .op_i (alu_op),
    .a_i  (alu_a),
    .b_i  (dbus),
    .y_o  (alu_y),
    .c_o  (alu_c)
  );

  assign dbus = drive ? wdata : 'z;
  assign run  = run_q;

  // NOTE: stop beats start, both act without a clock; HLT clears only on clk.
  always_ff @(posedge clk or posedge rst or posedge stop_sw or posedge start_sw) begin
    if (rst)           run_q <= 1'b0;
    else if (stop_sw)  run_q <= 1'b0;
    else if (start_sw) run_q <= 1'b1;
    else if (hlt)      run_q <= 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      p_q     <= sw;
      a_q     <= 12'd0;
      l_q     <= 1'b0;
      ir_op_q <= OP_LDA;
      ea_q    <= 12'd0;
      incp_q  <= 1'b0;
      dep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      l_q     <= l_d;
      ir_op_q <= ir_op_d;
      ea_q    <= ea_d;
      incp_q  <= incp_sw;
      dep_q   <= dep_sw;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    l_d     = l_q;
    ir_op_d = ir_op_q;
    ea_d    = ea_q;
    hlt     = 1'b0;
    abus    = 12'd0;
    rdm     = 1'b0;
    wrm     = 1'b0;
    drive   = 1'b0;
    wdata   = a_q;
    unique case (state_q)
      S_FETCH: begin
        if (run_q) begin
          abus    = p_q;
          rdm     = 1'b1;
          ir_op_d = f_op;
          p_d     = p_inc;
          ea_d    = direct_ea;
          if (f_op == OP_OPR) begin
            a_d = alu_y;
            l_d = l_opr;
            hlt = dbus[OPR_HLT];
            if (skip) p_d = p_inc + 12'd1;
          end else if (dbus[8])                       state_d = S_DEFER;
          else if (f_op == OP_JMP)                    p_d     = direct_ea;
          else if (f_op == OP_STA || f_op == OP_JSR)  state_d = S_WSETUP;
          else                                        state_d = S_READ;
        end else if (dep_rise) begin
          if (stop_sw) p_d = sw;
          else begin
            ea_d    = sw;
            state_d = S_PANEL_WS;
          end
        end else if (incp_rise) begin
          p_d = p_inc;
        end
      end
      S_DEFER: begin
        abus = ea_q;
        rdm  = 1'b1;
        ea_d = dbus;
        if (ir_op_q == OP_JMP) begin
          p_d     = dbus;
          state_d = S_FETCH;
        end else if (ir_op_q == OP_STA || ir_op_q == OP_JSR) state_d = S_WSETUP;
        else                                                  state_d = S_READ;
      end
      S_READ: begin
        abus = ea_q;
        rdm  = 1'b1;
        a_d  = alu_y;
        if (ir_op_q == OP_ADD) l_d = alu_c;
        state_d = S_FETCH;
      end
      S_WSETUP, S_WSTROBE: begin
        abus  = ea_q;
        drive = 1'b1;
        wdata = (ir_op_q == OP_JSR) ? p_q : a_q;
        wrm   = (state_q == S_WSTROBE);
        if (state_q == S_WSETUP) state_d = S_WSTROBE;
        else begin
          if (ir_op_q == OP_JSR) p_d = ea_q + 12'd1;
          state_d = S_FETCH;
        end
      end
      S_PANEL_WS, S_PANEL_WP: begin
        abus  = p_q;
        drive = 1'b1;
        wdata = ea_q;
        wrm   = (state_q == S_PANEL_WP);
        if (state_q == S_PANEL_WS) state_d = S_PANEL_WP;
        else begin
          p_d     = p_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_q2_cpu.sv
// Directed bench for q2_cpu: a behavioural 4K memory, expected writes queued in
// a scoreboard and checked by a monitor, plus panel/run/fetch-address checks.
module tb_q2_cpu;
  import q2_pkg::*;

  logic        clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  logic [11:0] sw = 12'd0;
  wire  [11:0] dbus;
  logic [11:0] abus;
  logic        rdm, wrm, run;
  logic        incp_sw = 1'b0, dep_sw = 1'b0, start_sw = 1'b0, stop_sw = 1'b0;

  int n_pass = 0, n_total = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [11:0] data;
  } wr_t;
  wr_t  exp_q[$];
  wr_t  exp_e;
  logic wrm_seen = 1'b0;

  logic [11:0] mem [0:4095];

  q2_cpu dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .dbus     (dbus),
    .abus     (abus),
    .rdm      (rdm),
    .wrm      (wrm),
    .incp_sw  (incp_sw),
    .dep_sw   (dep_sw),
    .start_sw (start_sw),
    .stop_sw  (stop_sw),
    .run      (run)
  );

  assign dbus = rdm ? mem[abus] : 'z;
  always @(posedge wrm) mem[abus] = dbus;

  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%03h, want 0x%03h", name, act, exp);
  endtask

  // Write monitor: each new wrm pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (wrm && !wrm_seen) begin
      if (exp_q.size() == 0) begin
        check("pending_write_count", 12'(exp_q.size()), 12'd1);
      end else begin
        exp_e = exp_q.pop_front();
        check("write_addr", abus, exp_e.addr);
        check("write_data", dbus, exp_e.data);
        check("write_rdm_low", {11'd0, rdm}, 12'd0);
      end
    end
    wrm_seen <= wrm;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_sw = 1'b1;
    #2;
    start_sw = 1'b0;
    #1;
  endtask

  task automatic run_until_halt(input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!run) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 4096; i++) mem[i] = 12'd0;
    // Program 1 at 0x800: LDA Z 10, ADD Z 11, STA Z 12, HLT
    mem[12'h010] = 12'h7FF;  mem[12'h011] = 12'h001;
    mem[12'h800] = 12'h090;  mem[12'h801] = 12'h291;
    mem[12'h802] = 12'h892;  mem[12'h803] = 12'hE01;
    // Program 2 at 0x804: L/skip checks, 0xFFF+2, indirect STA to I/O address
    mem[12'h013] = 12'hFFF;  mem[12'h014] = 12'h002;  mem[12'h07F] = IO_ADDR;
    mem[12'h804] = 12'hE80;  mem[12'h805] = 12'hE01;
    mem[12'h806] = 12'h093;  mem[12'h807] = 12'h294;
    mem[12'h808] = 12'hE80;  mem[12'h809] = 12'hE84;
    mem[12'h80A] = 12'hE01;  mem[12'h80B] = 12'h9FF;
    mem[12'h80C] = 12'hE01;

    sw = 12'h800;
    #1 rst = 1'b1;
    #20 rst = 1'b0;
    #5;
    check("reset_run", {11'd0, run}, 12'd0);
    check("reset_abus", abus, 12'h000);
    check("reset_rdm", {11'd0, rdm}, 12'd0);
    check("reset_wrm", {11'd0, wrm}, 12'd0);

    pulse_start();
    check("start_async_run", {11'd0, run}, 12'd1);
    check("first_fetch_abus", abus, 12'h800);
    check("first_fetch_rdm", {11'd0, rdm}, 12'd1);

    exp_q.push_back('{addr: 12'h012, data: 12'h800});
    clk_en = 1'b1;
    run_until_halt(50, cyc);
    check("prog1_cycles", 12'(cyc), 12'd8);
    check("prog1_mem12", mem[12'h012], 12'h800);

    check("halt_abus_idle", abus, 12'h000);
    check("halt_rdm_idle", {11'd0, rdm}, 12'd0);
    pulse_start();
    check("prog2_fetch_abus", abus, 12'h804);
    exp_q.push_back('{addr: IO_ADDR, data: 12'h001});
    run_until_halt(50, cyc);
    check("prog2_cycles", 12'(cyc), 12'd12);
    check("prog2_wrm_idle", {11'd0, wrm}, 12'd0);

    // JSR from 0x805, JMP I back to 0x806
    mem[12'h805] = 12'hCA0;  mem[12'h806] = 12'hE01;  mem[12'h021] = 12'hBA0;
    sw = 12'h805;  stop_sw = 1'b1;  dep_sw = 1'b1;
    tick(1);
    dep_sw = 1'b0;  stop_sw = 1'b0;
    tick(1);
    pulse_start();
    check("jsr_fetch_abus", abus, 12'h805);
    exp_q.push_back('{addr: 12'h020, data: 12'h806});
    tick(3);
    check("jsr_target_fetch", abus, 12'h021);
    tick(2);
    check("jmpi_return_fetch", abus, 12'h806);
    tick(1);
    check("jsr_prog_halted", {11'd0, run}, 12'd0);

    // Panel: set P, deposit, increment
    sw = 12'h100;  stop_sw = 1'b1;  dep_sw = 1'b1;
    tick(1);
    dep_sw = 1'b0;  stop_sw = 1'b0;
    tick(1);
    exp_q.push_back('{addr: 12'h100, data: 12'hABC});
    sw = 12'hABC;  dep_sw = 1'b1;
    tick(4);
    dep_sw = 1'b0;
    tick(1);
    check("panel_dep_mem", mem[12'h100], 12'hABC);
    incp_sw = 1'b1;
    tick(2);
    incp_sw = 1'b0;
    tick(1);
    mem[12'h102] = 12'hE01;  mem[12'h103] = 12'hA03;
    pulse_start();
    check("panel_p_after_incp", abus, 12'h102);
    tick(1);
    check("panel_prog_halted", {11'd0, run}, 12'd0);

    // Stop while spinning on JMP 0x103
    pulse_start();
    tick(3);
    check("spin_running", {11'd0, run}, 12'd1);
    check("spin_abus", abus, 12'h103);
    #2 stop_sw = 1'b1;
    #1;
    check("stop_async_run", {11'd0, run}, 12'd0);
    tick(1);
    stop_sw = 1'b0;
    tick(2);
    check("stopped_rdm", {11'd0, rdm}, 12'd0);
    check("stopped_run", {11'd0, run}, 12'd0);

    check("scoreboard_drained", 12'(exp_q.size()), 12'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
